// File: rtl/div_request_sequencer.sv
// Request front-end for the integer divider core: screens divide-by-zero, launches the core,
// and holds the result on a valid/ready port. Optional WAIT timeout guarded by DIV_TIMEOUT_EN.
module div_request_sequencer #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic             core_go,
   output logic             core_error,
   output logic [WIDTH-1:0] core_x,
   output logic [WIDTH-1:0] core_y,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_q,
   input  logic [WIDTH-1:0] core_r,
   output logic             core_abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic [1:0]       out_status,
   output logic             busy,
   output logic [7:0]       req_count
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             err_q, err_d;
   logic [1:0]       status_q, status_d;
   logic [7:0]       count_q, count_d;
   logic             timeout_hit;

`ifdef DIV_TIMEOUT_EN
   localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

   logic [TimerW-1:0] timer_q, timer_d;

   // Fires during the TIMEOUT-th WAIT cycle; a simultaneous core_done takes priority.
   assign timeout_hit = (state_q == StWait) && (timer_q == TimerW'(TIMEOUT - 1)) && !core_done;

   always_comb begin
      timer_d = timer_q;
      if (state_q == StIssue) begin
         timer_d = '0;
      end else if (state_q == StWait) begin
         timer_d = timer_q + TimerW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      err_d    = err_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      status_d = status_q;
      count_d  = count_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               x_d   = in_dividend;
               y_d   = in_divisor;
               err_d = (in_divisor == '0);
               if (in_divisor == '0) begin
                  // Answered locally; the core never sees this request.
                  quo_d    = '1;
                  rem_d    = in_dividend;
                  status_d = 2'b01;
                  state_d  = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (core_done) begin
               quo_d    = core_q;
               rem_d    = core_r;
               status_d = 2'b00;
               state_d  = StResp;
            end else if (timeout_hit) begin
               quo_d    = '0;
               rem_d    = '0;
               status_d = 2'b10;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (out_ready) begin
               count_d = count_q + 8'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         err_q    <= 1'b0;
         quo_q    <= '0;
         rem_q    <= '0;
         status_q <= 2'b00;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         err_q    <= err_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         status_q <= status_d;
         count_q  <= count_d;
      end
   end

   assign in_ready      = (state_q == StIdle);
   assign core_go       = (state_q == StIssue);
   assign out_valid     = (state_q == StResp);
   assign busy          = (state_q != StIdle);
   assign core_abort    = timeout_hit;
   assign core_error    = err_q;
   assign core_x        = x_q;
   assign core_y        = y_q;
   assign out_quotient  = quo_q;
   assign out_remainder = rem_q;
   assign out_status    = status_q;
   assign req_count     = count_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer with a behavioural divider core model.
// Build with +define+DIV_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_div_request_sequencer;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [W-1:0] in_dividend, in_divisor;
   logic         core_go, core_error, core_done, core_abort;
   logic [W-1:0] core_x, core_y, core_q, core_r;
   logic         out_valid, out_ready, busy;
   logic [W-1:0] out_quotient, out_remainder;
   logic [1:0]   out_status;
   logic [7:0]   req_count;

   int n_checks = 0;
   int n_errors = 0;

   div_request_sequencer #(.WIDTH(W), .TIMEOUT(31)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .core_go       (core_go),
      .core_error    (core_error),
      .core_x        (core_x),
      .core_y        (core_y),
      .core_done     (core_done),
      .core_q        (core_q),
      .core_r        (core_r),
      .core_abort    (core_abort),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_status    (out_status),
      .busy          (busy),
      .req_count     (req_count)
   );

   always #5 clk = ~clk;

   // Divider core model: answers model_delay cycles after go when enabled.
   logic model_en = 1'b1;
   int   model_delay = 3;
   logic spurious_done = 1'b0;
   logic pend;
   int   dly;
   int   go_cnt = 0;
   int   abort_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 1'b0;
         dly  <= 0;
      end else if (core_go && model_en) begin
         pend <= 1'b1;
         dly  <= model_delay;
      end else if (pend && dly == 0) begin
         pend <= 1'b0;
      end else if (pend) begin
         dly <= dly - 1;
      end
   end

   always @(posedge clk) begin
      if (core_go) go_cnt <= go_cnt + 1;
      if (core_abort) abort_cnt <= abort_cnt + 1;
   end

   assign core_done = (pend && dly == 0) || spurious_done;
   assign core_q    = (core_y == '0) ? '1 : core_x / core_y;
   assign core_r    = (core_y == '0) ? core_x : core_x % core_y;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < budget) begin
         step();
         cycles++;
      end
      check("out_valid_within_budget", out_valid, 1'b1);
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid    = 1'b1;
      in_dividend = x;
      in_divisor  = y;
      step();
      in_valid = 1'b0;
   endtask

   int cyc;
   int go_base;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_dividend = '0;
      in_divisor = '0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_core_go", core_go, 1'b0);
      check("rst_core_abort", core_abort, 1'b0);
      check("rst_quotient", out_quotient, 4'h0);
      check("rst_remainder", out_remainder, 4'h0);
      check("rst_status", out_status, 2'b00);
      check("rst_req_count", req_count, 8'd0);
      check("rst_core_x", core_x, 4'h0);
      rst = 1'b0;
      step();

      // 13 / 3 through the core
      send(4'd13, 4'd3);
      check("go_after_accept", core_go, 1'b1);
      check("busy_in_issue", busy, 1'b1);
      check("in_ready_in_issue", in_ready, 1'b0);
      check("core_x_13", core_x, 4'd13);
      check("core_y_3", core_y, 4'd3);
      check("core_error_clear", core_error, 1'b0);
      step();
      check("go_single_cycle", core_go, 1'b0);
      wait_valid(50, cyc);
      check("q_13_3", out_quotient, 4'd4);
      check("r_13_3", out_remainder, 4'd1);
      check("status_13_3", out_status, 2'b00);
      check("go_count_13_3", go_cnt, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("req_count_1", req_count, 8'd1);
      check("idle_after_13_3", in_ready, 1'b1);

      // 13 / 0 answered locally in the cycle after acceptance
      send(4'd13, 4'd0);
      check("div0_valid_next_cycle", out_valid, 1'b1);
      check("div0_core_error", core_error, 1'b1);
      check("div0_q", out_quotient, 4'hF);
      check("div0_r", out_remainder, 4'd13);
      check("div0_status", out_status, 2'b01);
      check("div0_no_go", go_cnt, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("req_count_2", req_count, 8'd2);

      // 9 / 2 with the consumer stalling for 5 cycles and a competing request
      send(4'd9, 4'd2);
      wait_valid(50, cyc);
      in_valid    = 1'b1;
      in_dividend = 4'd5;
      in_divisor  = 4'd1;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", out_valid, 1'b1);
         check("stall_q", out_quotient, 4'd4);
         check("stall_r", out_remainder, 4'd1);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_core_x", core_x, 4'd9);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("req_count_3", req_count, 8'd3);
      check("idle_after_stall", in_ready, 1'b1);
      check("no_valid_after_stall", out_valid, 1'b0);
      check("go_count_9_2", go_cnt, 2);

`ifdef DIV_TIMEOUT_EN
      // Core never answers: 31 WAIT cycles, then abort and status 10
      model_en = 1'b0;
      send(4'd10, 4'd3);
      wait_valid(100, cyc);
      check("timeout_latency", cyc, 32);
      check("timeout_abort_once", abort_cnt, 1);
      check("timeout_q", out_quotient, 4'd0);
      check("timeout_r", out_remainder, 4'd0);
      check("timeout_status", out_status, 2'b10);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("req_count_4", req_count, 8'd4);
      model_en = 1'b1;
`endif

      // Reset while waiting on the core, then a spurious core_done
      model_en = 1'b0;
      send(4'd8, 4'd2);
      step();
      step();
      check("busy_in_wait", busy, 1'b1);
      go_base = go_cnt;
      rst = 1'b1;
      #1;
      check("async_rst_idle", in_ready, 1'b1);
      step();
      rst = 1'b0;
      spurious_done = 1'b1;
      step();
      spurious_done = 1'b0;
      step();
      step();
      check("post_rst_idle", in_ready, 1'b1);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_req_count", req_count, 8'd0);
      check("post_rst_no_go", go_cnt, go_base);
      model_en = 1'b1;

      // 256 back-to-back 7 / 1 requests with both handshakes held high
      model_delay = 0;
      go_base     = go_cnt;
      in_valid    = 1'b1;
      in_dividend = 4'd7;
      in_divisor  = 4'd1;
      out_ready   = 1'b1;
      for (int i = 0; i < 256; i++) begin
         wait_valid(20, cyc);
         check("b2b_q", out_quotient, 4'd7);
         check("b2b_r", out_remainder, 4'd0);
         check("b2b_status", out_status, 2'b00);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      check("wrap_req_count", req_count, 8'd0);
      check("b2b_go_count", go_cnt - go_base, 256);
`ifndef DIV_TIMEOUT_EN
      check("no_abort_default", abort_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
